dat_mem_seq: RTL
================

Name: dat_mem_seq

Overview:
- Bus-master sequencer that drives the single-port 8-bit x 256 data memory from the initiator side. The memory has combinational read and clocked write.
- Executes one block command per start:
  - COPY: src -> dst
  - FILL: constant -> dst
  - CHECKSUM: sum of a src range
- Sits between the controller/testbench and the data memory, and owns the memory address, write-data and write-enable lines while busy.

Parameters:
- AW, 8, memory address width; addresses wrap modulo 2^AW.
- DW, 8, memory data width.
- SW, 16, checksum accumulator width.

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  synchronous, active-high.
- start  input  1  command strobe; sampled only in IDLE.
- op  input  2  command: 0 = COPY, 1 = FILL, 2 = CHECKSUM, 3 = reserved.
- src_addr  input  AW  first source address (COPY, CHECKSUM).
- dst_addr  input  AW  first destination address (COPY, FILL).
- length  input  AW+1  byte count, 0..256.
- fill_val  input  DW  FILL data.
- busy  output  1  high while memory accesses are in progress.
- done  output  1  one-cycle pulse at command completion.
- sum  output  SW  CHECKSUM result; held until the next accepted start.
- mem_addr  output  AW  memory address.
- mem_wr_data  output  DW  memory write data.
- mem_wr_en  output  1  memory write enable.
- mem_rd_data  input  DW  combinational memory read data for mem_addr.

Behaviour:
- Reset: state = IDLE; busy = 0, done = 0, sum = 0, mem_addr = 0, mem_wr_data = 0, mem_wr_en = 0.
  - Reset mid-command aborts immediately: no further writes and no done pulse.
  - Memory contents written before the abort are not undone.
- Command capture: at a posedge in IDLE with start = 1, latch op, src, dst, length and fill_val into internal registers.
  - Inputs may change afterwards.
  - start is ignored in every state other than IDLE.
- Initial state on capture:
  - length = 0 or op = 3: go to DONE; no memory access.
  - Otherwise: CHECKSUM clears sum to 0; COPY/CHECKSUM go to RD; FILL goes to WR.
- States:
  - IDLE
  - RD: mem_addr = src pointer, mem_wr_en = 0.
  - WR: mem_addr = dst pointer, mem_wr_en = 1.
  - DONE
- Outputs in IDLE/DONE: mem_addr = 0, mem_wr_en = 0, mem_wr_data = 0.
- busy = 1 exactly in RD and WR.
- done = 1 exactly in DONE. DONE lasts one cycle and then goes to IDLE, so a new start can be accepted on the cycle after done.
- COPY, 2 cycles per byte:
  - RD: capture mem_rd_data into a holding register at the posedge.
  - WR: mem_wr_data = holding register.
  - After WR: src++, dst++, remaining--. If remaining becomes 0, go to DONE; else go to RD.
- FILL, 1 cycle per byte: stay in WR with mem_wr_data = fill_val. dst++ and remaining-- each cycle; go to DONE when remaining becomes 0.
- CHECKSUM, 1 cycle per byte: stay in RD. sum <= sum + mem_rd_data (zero-extended, modulo 2^SW) each cycle; src++ and remaining--; go to DONE when remaining becomes 0.
- Latency from the start-accept edge to the done cycle: 2N+1 cycles for COPY, N+1 for FILL/CHECKSUM, 1 for N = 0.
- Pointers wrap 255 -> 0; length = 256 covers the whole memory.
- Overlapping COPY proceeds in ascending address order (no memmove semantics). If dst = src+1, src[0] propagates through the range.
- mem_wr_en is never asserted outside WR. At most one memory write per cycle.

Test Plan:
- Reset, then start COPY with src = 4, dst = 20, length = 3, memory[4..6] = 00,01,FF -> writes at 20,21,22 = 00,01,FF; busy high 6 cycles; done pulses on the 7th cycle after accept.
- FILL with dst = 254, length = 4, fill_val = A5 -> writes A5 to 254, 255, 0, 1 on 4 consecutive cycles; mem_wr_en high exactly 4 cycles.
- CHECKSUM with src = 0, length = 256, memory[i] = i -> sum = 0x7F80; done 257 cycles after accept; sum holds 0x7F80 in IDLE.
- Start with length = 0, and separately with op = 3 -> done on the next cycle, busy never high, no memory access; a start pulsed while busy during another command is ignored.
- Reset asserted in the second WR of a COPY with length = 5 -> next cycle IDLE with all outputs at reset values; only 1 byte written; no done pulse.
- COPY with src = 10, dst = 11, length = 3, memory[10] = 7 -> memory[11..13] all equal 7.

Source files
------------

// File: rtl/dat_mem_seq.sv
// Block-command sequencer driving a single-port memory (combinational read,
// clocked write): COPY, FILL and CHECKSUM over an address range that wraps.
module dat_mem_seq #(
   parameter int AW = 8,
   parameter int DW = 8,
   parameter int SW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [1:0]    op,
   input  logic [AW-1:0] src_addr,
   input  logic [AW-1:0] dst_addr,
   input  logic [AW:0]   length,
   input  logic [DW-1:0] fill_val,
   output logic          busy,
   output logic          done,
   output logic [SW-1:0] sum,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wr_data,
   output logic          mem_wr_en,
   input  logic [DW-1:0] mem_rd_data
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_WR   = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [1:0] OP_COPY = 2'd0;
   localparam logic [1:0] OP_FILL = 2'd1;
   localparam logic [1:0] OP_SUM  = 2'd2;
   localparam logic [1:0] OP_RSV  = 2'd3;

   localparam logic [AW-1:0] ONE_A = 1;
   localparam logic [AW:0]   ONE_R = 1;

   logic [1:0]    r_state;
   logic [1:0]    r_op;
   logic [AW-1:0] r_src;
   logic [AW-1:0] r_dst;
   logic [AW:0]   r_rem;
   logic [DW-1:0] r_fill;
   logic [DW-1:0] r_hold;
   logic [SW-1:0] r_sum;

   logic          w_last;
   logic [SW-1:0] w_rd_ext;

   assign w_last   = (r_rem == ONE_R);
   assign w_rd_ext = {{(SW-DW){1'b0}}, mem_rd_data};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_sum   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_op   <= op;
                  r_src  <= src_addr;
                  r_dst  <= dst_addr;
                  r_rem  <= length;
                  r_fill <= fill_val;
                  if (length == '0 || op == OP_RSV) begin
                     r_state <= S_DONE;
                  end else if (op == OP_FILL) begin
                     r_state <= S_WR;
                  end else begin
                     r_state <= S_RD;
                     if (op == OP_SUM) r_sum <= '0;
                  end
               end
            end
            S_RD: begin
               if (r_op == OP_SUM) begin
                  r_sum <= r_sum + w_rd_ext;
                  r_src <= r_src + ONE_A;
                  r_rem <= r_rem - ONE_R;
                  if (w_last) r_state <= S_DONE;
               end else begin
                  r_hold  <= mem_rd_data;
                  r_state <= S_WR;
               end
            end
            S_WR: begin
               r_dst <= r_dst + ONE_A;
               r_rem <= r_rem - ONE_R;
               if (r_op == OP_COPY) r_src <= r_src + ONE_A;
               if (w_last)                r_state <= S_DONE;
               else if (r_op == OP_COPY)  r_state <= S_RD;
               else                       r_state <= S_WR;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Write enable is gated by reset so an abort suppresses the in-flight write.
   always_comb begin
      mem_addr    = '0;
      mem_wr_data = '0;
      mem_wr_en   = 1'b0;
      case (r_state)
         S_RD: mem_addr = r_src;
         S_WR: begin
            mem_addr    = r_dst;
            mem_wr_data = (r_op == OP_FILL) ? r_fill : r_hold;
            mem_wr_en   = !reset;
         end
         default: ;
      endcase
   end

   assign busy = (r_state == S_RD) || (r_state == S_WR);
   assign done = (r_state == S_DONE);
   assign sum  = r_sum;

endmodule
